// File: rtl/bvh_traversal_ctrl.sv
// BVH traversal controller: walks one ray through the node tree,
// keeping deferred far children on a small stack and emitting hit leaves.
package bvh_pkg;
  localparam int FX_W = 24;

  typedef logic [FX_W-1:0] fx_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } vec3_t;

  typedef struct packed {
    fx_t tmin;
    fx_t tmax;
  } vec2_t;

  typedef struct packed {
    vec3_t lo;
    vec3_t hi;
  } bbox_t;
endpackage

module bvh_traversal_ctrl
  import bvh_pkg::*;
#(
  parameter int IDX_W       = 16,
  parameter int STACK_DEPTH = 32,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  vec3_t            ray_orig_in,
  input  vec3_t            inv_dir_in,
  input  vec2_t            t_range_in,
  output logic             node_req,
  output logic [IDX_W-1:0] node_addr,
  input  logic             node_ack,
  input  bbox_t            node_box,
  input  logic             node_is_leaf,
  input  logic [IDX_W-1:0] node_child,
  input  logic [IDX_W-1:0] node_prim,
  input  logic [CNT_W-1:0] node_prim_cnt,
  output vec3_t            isect_orig,
  output vec3_t            isect_inv_dir,
  output bbox_t            isect_box,
  output vec2_t            isect_range,
  input  logic             isect_hit,
  input  vec2_t            isect_range_o,
  output logic             leaf_valid,
  input  logic             leaf_ready,
  output logic [IDX_W-1:0] leaf_prim,
  output logic [CNT_W-1:0] leaf_cnt,
  output vec2_t            leaf_range,
  output logic             done,
  output logic             overflow
);

  localparam int AW   = $clog2(STACK_DEPTH);
  localparam int SP_W = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    TEST,
    LEAF,
    POP,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    vec2_t            rng;
  } stk_t;

  state_t           state;
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] cur_idx;
  vec2_t            cur_range;
  logic             n_leaf;
  logic [IDX_W-1:0] n_child;
  logic [IDX_W-1:0] n_prim;
  logic [CNT_W-1:0] n_cnt;

  stk_t             stack [STACK_DEPTH];
  stk_t             top;
  stk_t             push_ent;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             sp_full;
  logic             descend;
  logic             do_push;

  assign node_addr   = cur_idx;
  assign isect_range = cur_range;

  assign wr_ptr  = sp[AW-1:0];
  assign rd_ptr  = wr_ptr - AW'(1);
  assign top     = stack[rd_ptr];
  assign sp_full = (sp == SP_W'(STACK_DEPTH));
  assign descend = (state == TEST) && isect_hit && !n_leaf;
  assign do_push = descend && !sp_full;

  assign push_ent.idx = n_child + IDX_W'(1);
  assign push_ent.rng = isect_range_o;

  // Entries above sp are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ray_ready     <= 1'b1;
      sp            <= '0;
      cur_idx       <= '0;
      cur_range     <= '0;
      n_leaf        <= 1'b0;
      n_child       <= '0;
      n_prim        <= '0;
      n_cnt         <= '0;
      node_req      <= 1'b0;
      isect_orig    <= '0;
      isect_inv_dir <= '0;
      isect_box     <= '0;
      leaf_valid    <= 1'b0;
      leaf_prim     <= '0;
      leaf_cnt      <= '0;
      leaf_range    <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ray_valid) begin
            isect_orig    <= ray_orig_in;
            isect_inv_dir <= inv_dir_in;
            cur_idx       <= '0;
            cur_range     <= t_range_in;
            sp            <= '0;
            overflow      <= 1'b0;
            ray_ready     <= 1'b0;
            node_req      <= 1'b1;
            state         <= FETCH;
          end
        end
        FETCH: begin
          if (node_ack) begin
            isect_box <= node_box;
            n_leaf    <= node_is_leaf;
            n_child   <= node_child;
            n_prim    <= node_prim;
            n_cnt     <= node_prim_cnt;
            node_req  <= 1'b0;
            state     <= TEST;
          end
        end
        TEST: begin
          if (!isect_hit) begin
            state <= POP;
          end else if (n_leaf) begin
            leaf_valid <= 1'b1;
            leaf_prim  <= n_prim;
            leaf_cnt   <= n_cnt;
            leaf_range <= isect_range_o;
            state      <= LEAF;
          end else begin
            // A full stack loses the far child but the near one still descends.
            if (sp_full) begin
              overflow <= 1'b1;
            end else begin
              sp <= sp + SP_W'(1);
            end
            cur_idx   <= n_child;
            cur_range <= isect_range_o;
            node_req  <= 1'b1;
            state     <= FETCH;
          end
        end
        LEAF: begin
          if (leaf_ready) begin
            leaf_valid <= 1'b0;
            state      <= POP;
          end
        end
        POP: begin
          if (sp == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sp        <= sp - SP_W'(1);
            cur_idx   <= top.idx;
            cur_range <= top.rng;
            node_req  <= 1'b1;
            state     <= FETCH;
          end
        end
        DONE: begin
          ray_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
